// File: rtl/pkt_frame_ctrl_pkg.sv
// Shared types and helpers for the multi-channel packet framing controller.
package pkt_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_MAX_LEN = 64;
  localparam int DEF_TIMEOUT = 256;

  // Zero or oversize lengths fall back to the maximum packet length.
  function automatic int unsigned clamp_len(input int unsigned cfg, input int unsigned max_len);
    return (cfg == 0 || cfg > max_len) ? max_len : cfg;
  endfunction

endpackage

// File: rtl/pkt_frame_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module pkt_frame_ctrl_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   idx
);

  logic            found;
  logic [CH_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = CH_W'((32'(ptr) + 32'(i)) % NUM_CH);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/pkt_frame_ctrl.sv
// Round-robin multi-channel packet framer producing sop/eop/wren and a commit pulse.
// Optional stall watchdog enabled by defining PKT_FRAME_CTRL_WDOG_EN.
module pkt_frame_ctrl
  import pkt_frame_ctrl_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk_hifreq,
  input  logic              rst,
  input  logic              en,
  input  logic              rdy,
  input  logic [LEN_W-1:0]  len_cfg,
  input  logic [NUM_CH-1:0] ch_req,
  output logic [NUM_CH-1:0] ch_grant,
  output logic [CH_W-1:0]   ch_sel,
  output logic              sop,
  output logic              eop,
  output logic              wren,
  output logic              reg_wren,
  output logic              busy,
  output logic [LEN_W-1:0]  beat_cnt,
  output logic              err
);

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] grant_q;
  logic [CH_W-1:0]   sel_q;
  logic [CH_W-1:0]   ptr_q;
  logic [LEN_W-1:0]  beat_q;
  logic [LEN_W-1:0]  len_q;
  logic [NUM_CH-1:0] arb_gnt;
  logic [CH_W-1:0]   arb_idx;
  logic [CH_W-1:0]   next_ptr;
  logic              start, finish, abort, wd_fire;

  pkt_frame_ctrl_rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
    .req (ch_req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign next_ptr = (32'(sel_q) == 32'(NUM_CH - 1)) ? '0 : sel_q + CH_W'(1);

`ifdef PKT_FRAME_CTRL_WDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wdog_q;

  // Counts consecutive stalled XFER cycles; any beat or leaving XFER restarts it.
  always_ff @(posedge clk_hifreq) begin
    if (!rst || state_q != XFER || rdy) wdog_q <= '0;
    else                                wdog_q <= wdog_q + WD_W'(1);
  end

  assign wd_fire = (state_q == XFER) && !rdy && (wdog_q == WD_W'(TIMEOUT - 1));
`else
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    finish  = 1'b0;
    abort   = 1'b0;
    wren    = 1'b0;
    sop     = 1'b0;
    eop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && (|ch_req)) begin
          start   = 1'b1;
          state_d = XFER;
        end
      end
      XFER: begin
        wren = rdy;
        sop  = rdy && (beat_q == '0);
        eop  = rdy && (beat_q == len_q - LEN_W'(1));
        if (eop) begin
          state_d = DONE;
        end else if (wd_fire) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      DONE: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_hifreq) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      beat_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        grant_q <= arb_gnt;
        sel_q   <= arb_idx;
        len_q   <= LEN_W'(clamp_len(32'(len_cfg), 32'(MAX_LEN)));
      end
      if (wren) beat_q <= beat_q + LEN_W'(1);
      // Completed or aborted packets both move the pointer past the served channel.
      if (finish || abort) begin
        grant_q <= '0;
        beat_q  <= '0;
        ptr_q   <= next_ptr;
      end
    end
  end

  assign ch_grant = grant_q;
  assign ch_sel   = sel_q;
  assign beat_cnt = beat_q;
  assign reg_wren = (state_q == DONE);
  assign busy     = (state_q != IDLE);
  assign err      = wd_fire;

endmodule

// File: doc/pkt_frame_ctrl.md
Name: pkt_frame_ctrl

Overview:
Parametrised multi-channel packet framing controller; successor to the single-channel sop/eop/wren controller in the feed-handler write path. Arbitrates round-robin among NUM_CH requesting channels and frames each granted transfer into a run-time-configurable length of beats. Generates sop/eop/wren against a downstream rdy backpressure, plus a reg_wren commit pulse per completed packet. Sits between the channel ingress buffers and the packet store.

Parameters:
NUM_CH, 4, number of requesting channels (≥1)
MAX_LEN, 64, maximum beats per packet (≥1)
LEN_W, $clog2(MAX_LEN+1), width of len_cfg and beat_cnt
CH_W, (NUM_CH>1 ? $clog2(NUM_CH) : 1), width of ch_sel
TIMEOUT, 256, stall-watchdog limit in cycles (used only with the optional feature)

Ports:
clk_hifreq  in  1  single clock, rising edge
rst  in  1  synchronous, active-low reset
en  in  1  global enable; gates the start of new packets only
rdy  in  1  downstream ready; a beat occurs on a cycle in XFER with rdy=1
len_cfg  in  LEN_W  packet length, sampled at grant; 0 or >MAX_LEN → MAX_LEN
ch_req  in  NUM_CH  per-channel request, level
ch_grant  out  NUM_CH  one-hot grant, held for the whole packet
ch_sel  out  CH_W  binary index of the granted channel
sop  out  1  first beat of packet
eop  out  1  last beat of packet
wren  out  1  beat strobe
reg_wren  out  1  one-cycle commit pulse after eop
busy  out  1  high in any state other than IDLE
beat_cnt  out  LEN_W  beats completed in the current packet
err  out  1  watchdog abort pulse (tied 0 without the feature)

Behaviour:
- Reset (rst=0 at an edge): state=IDLE; ch_grant=0, ch_sel=0, beat_cnt=0, len register=0, rr pointer=0, watchdog=0. All outputs are 0 in the same cycle. Reset mid-packet abandons the packet immediately with no eop and no reg_wren.
- FSM states: IDLE, XFER, DONE.
- IDLE: if en=1 and ch_req≠0, grant the first requester at or after the pointer in ascending index order, wrapping. Latch the clamped len_cfg. Go to XFER. Grant and ch_sel are registered and visible in the next cycle.
- XFER:
  - wren = rdy. This is Mealy: combinational from registered state and rdy.
  - sop = wren & (beat_cnt==0). eop = wren & (beat_cnt==len-1).
  - beat_cnt increments on each wren.
  - An eop beat moves the FSM to DONE.
  - rdy=0 stalls: no strobes, counters hold.
- len=1: sop and eop assert together on a single beat.
- DONE: reg_wren=1 for exactly one cycle. ch_grant clears, beat_cnt clears, pointer = granted index+1 (mod NUM_CH). Go to IDLE.
- Minimum packet spacing: IDLE→XFER→DONE→IDLE. A back-to-back request is granted in the IDLE cycle after DONE, so there are at least 2 dead cycles between an eop and the next sop.
- en dropping mid-packet does not truncate; the packet completes. en dropping in IDLE blocks new grants.
- Dropping ch_req of the granted channel mid-packet is ignored; the packet completes.
- Latency: a request seen in IDLE at cycle N gives its first possible beat at N+1.
- ch_grant is always one-hot or zero; never more than one channel is granted.

Optional Feature:
- Macro: PKT_FRAME_CTRL_WDOG_EN.
- Defined: a counter runs while the FSM is in XFER with rdy=0 and clears on any beat. When it reaches TIMEOUT-1, err pulses for 1 cycle, the FSM goes directly to IDLE, grant and beat_cnt clear, the pointer advances past the aborted channel, and no eop or reg_wren is issued.
- Undefined: no counter is built, err is tied 0, and stalls are unbounded.

Decomposition:
- pkt_frame_ctrl_pkg holds:
  - the state enum (state_t: IDLE, XFER, DONE);
  - default constants for MAX_LEN and TIMEOUT;
  - the clamp function for len_cfg.
- Sub-module rr_arbiter (NUM_CH parameter; inputs req and ptr; outputs one-hot gnt and index) is purely combinational, used from IDLE only.

Test Plan:
- Reset then single channel: en=1, rdy=1, ch_req=4'b0001, len_cfg=4 → ch_sel=0; 4 wren beats, sop on beat 0, eop on beat 3; reg_wren 1 cycle later; busy drops.
- Backpressure: len_cfg=3, rdy pattern 1,0,0,1,1 → exactly 3 wren, beat_cnt goes 0,1,1,1,2,3; sop and eop only on beats 0 and 2.
- Round-robin: ch_req=4'b1011 held, len_cfg=1 → grant order 0,1,3,0; each packet has sop=eop on the same cycle.
- Length edge cases: len_cfg=0 and len_cfg=MAX_LEN+5 each produce exactly 64 beats; en dropped at beat 10 still completes the packet, and no new grant follows.
- Reset mid-packet: rst=0 at beat 2 of 8 → the next cycle shows all outputs 0 and no reg_wren; after release with ch_req=4'b0100, the next grant is channel 2 (pointer reset to 0).
- With PKT_FRAME_CTRL_WDOG_EN and TIMEOUT=8: rdy held 0 in XFER → err pulses on the 8th stall cycle, FSM returns to IDLE, no eop or reg_wren, and the next grant skips the aborted channel.
